cntrl_spi_regs: RTL and testbench
=================================

// Module: cntrl_spi_regs
// PURPOSE
//  Control register bank consuming the SPI slave's parallel bus (addr, data, wr_en, rd_en).
//  It decodes the 7-bit address and holds the control/status registers that drive the rest of the FPGA.
//  It supplies read data back to the slave for MISO serialisation.
//  The block is single-clock and sits between spi_slave and the reset, IRQ, LED, ADC DPRAM, DDC and audio mux logic.
// PARAMETERS
//  ID_VALUE          32'h1C3A0001  value returned by ID register
//  DPRAM_AW          10            ADC DPRAM address width
//  RST_WIDTH         4             number of sub-block reset outputs
//  RST_PULSE_CYCLES  16            clk cycles a requested reset is held
//  IRQ_WIDTH         8             number of IRQ sources (max 16)
// PORTS
//  clk              in   1          system clock
//  reset            in   1          asynchronous, active-high reset
//  addr             in   7          register address from spi_slave
//  wr_data          in   32         write data from spi_slave
//  rd_data          out  32         read data to spi_slave; combinational mux on addr
//  wr_en            in   1          1-clk write strobe, clk-synchronous
//  rd_en            in   1          1-clk read-complete strobe, clk-synchronous
//  rst_out          out  RST_WIDTH  sub-block resets, active-high
//  irq_src          in   IRQ_WIDTH  IRQ source levels, clk-synchronous
//  irq              out  1          |(status & enable)
//  led              out  2          LED control
//  dpram_addr       out  DPRAM_AW   ADC DPRAM read address
//  dpram_rdata      in   32         ADC DPRAM read data, 1-clk synchronous RAM
//  ddc_en           out  1          DDC enable
//  ddc_lo_freq      out  32         DDC LO tuning word
//  ddc_lo_freq_upd  out  1          1-clk strobe after LO write
//  i2s_mux_sel      out  2          audio I2S mux select
// BEHAVIOUR
//  Register map (unmapped: read 0, write ignored; unused bits read 0):
//   0x00 ID RO = ID_VALUE
//   0x01 RST_CNTRL: write 1 to bit n asserts rst_out[n]; read returns rst_out
//   0x02 IRQ_CNTRL_STATUS: [IRQ_WIDTH-1:0] enable RW; [16+IRQ_WIDTH-1:16] status W1C
//   0x03 LED_CNTRL [1:0] RW       0x10 ADC_DPRAM_CNTRL [0] AINC RW
//   0x11 ADC_DPRAM_ADDR RW        0x12 ADC_DPRAM_DATA RO = dpram_rdata
//   0x20 DDC_CNTRL [0] ddc_en RW  0x21 DDC_LO_FREQ RW   0x30 AUDIO_I2S_MUX_SEL [1:0] RW
//  Writes take effect on the clk edge where wr_en=1; outputs change the next cycle.
//  Reset values:
//   - rst_out all ones and rst counter = RST_PULSE_CYCLES, so sub-blocks release RST_PULSE_CYCLES clks after reset deasserts.
//   - All other registers and outputs are 0; irq=0; ddc_lo_freq_upd=0.
//  Reset pulse: one shared down-counter.
//   - A write ORs the new bits into rst_out and reloads the counter.
//   - At count 0, rst_out clears to 0.
//   - Writing 0 has no effect.
//  IRQ:
//   - A rising edge of irq_src[n] (registered previous value) sets status[n].
//   - W1C clears status; a set and a clear in the same cycle -> set wins.
//   - irq is registered: 1-clk latency from the status change.
//  DPRAM:
//   - rd_en at 0x12 with AINC=1 post-increments dpram_addr, wrapping from 2^DPRAM_AW-1 to 0.
//   - dpram_rdata is valid 1 clk after a dpram_addr change.
//   - With AINC=0, the address is unchanged.
//  DDC LO: ddc_lo_freq_upd pulses the cycle ddc_lo_freq takes the new value.
//  wr_en and rd_en together: the write is performed and read side effects (auto-increment) are suppressed.
//  Reset mid-operation: everything returns to reset values immediately (async); a pending rst pulse restarts at full length.
// STRUCTURE
//  - cntrl_spi_regs_defs.vh: register address localparams (0x00..0x30) and field bit positions, shared with firmware headers and benches.
//  - Sub-module cntrl_rst_pulse: counter plus rst_out register, parameterised RST_WIDTH and RST_PULSE_CYCLES.
//  - Everything else stays flat in this module.
// TESTING
//  1. Reset -> rst_out=4'hF for exactly 16 clks after deassert, then 0; read 0x00 = 32'h1C3A0001.
//  2. Write 0x01=4'h2; write 0x01=4'h4 at cycle 10 -> rst_out=4'h6 until 16 clks after the second write, then 0.
//  3. Write 0x02 enable=8'h05; irq_src[0] 0->1 -> status bit16=1, irq=1 next clk.
//     - W1C 0x00010000 in the same cycle as a new irq_src[0] edge -> bit stays set.
//  4. AINC=1, ADDR=0x3FF; rd_en at 0x12 -> dpram_addr=0x000; second read -> 0x001.
//     - rd_en with AINC=0 -> unchanged.
//  5. Write 0x21=32'h12345678 -> ddc_lo_freq=32'h12345678 and a single 1-clk ddc_lo_freq_upd; read back matches.
//  6. Write 0x7F=32'hFFFFFFFF -> no output changes; read 0x7F = 0; read 0x03 after writing 32'hFFFFFFFF = 32'h3.

Source files
------------

// File: rtl/cntrl_spi_regs_pkg.sv
// ---------------------------------------------------------------------------
// cntrl_spi_regs_pkg
//   Shared definitions for the SPI control register bank: register map
//   addresses and field bit positions used by the RTL, the benches and the
//   firmware headers generated from them.
// ---------------------------------------------------------------------------
package cntrl_spi_regs_pkg;

  // 7-bit register addresses as seen on the spi_slave parallel bus
  typedef enum logic [6:0] {
    REG_ID                = 7'h00,
    REG_RST_CNTRL         = 7'h01,
    REG_IRQ_CNTRL_STATUS  = 7'h02,
    REG_LED_CNTRL         = 7'h03,
    REG_ADC_DPRAM_CNTRL   = 7'h10,
    REG_ADC_DPRAM_ADDR    = 7'h11,
    REG_ADC_DPRAM_DATA    = 7'h12,
    REG_DDC_CNTRL         = 7'h20,
    REG_DDC_LO_FREQ       = 7'h21,
    REG_AUDIO_I2S_MUX_SEL = 7'h30
  } reg_addr_e;

  // Field positions
  localparam int IRQ_STATUS_LSB = 16;  // status field starts at bit 16
  localparam int IRQ_MAX_WIDTH  = 16;  // enable and status each own 16 bits
  localparam int DPRAM_AINC_BIT = 0;
  localparam int DDC_EN_BIT     = 0;

endpackage

// File: rtl/cntrl_rst_pulse.sv
// ---------------------------------------------------------------------------
// cntrl_rst_pulse
//   Holds the sub-block reset outputs and the single shared down-counter
//   that stretches every reset request to RST_PULSE_CYCLES clocks.
//   Ports:
//     clk, reset  - system clock, asynchronous active-high reset
//     load        - request strobe (only asserted with at least one bit set)
//     set_bits    - reset bits to OR into rst_out
//     rst_out     - registered sub-block resets, active-high
// ---------------------------------------------------------------------------
module cntrl_rst_pulse #(
  parameter int RST_WIDTH        = 4,
  parameter int RST_PULSE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [RST_WIDTH-1:0] set_bits,
  output logic [RST_WIDTH-1:0] rst_out
);

  localparam int                CNT_W    = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RST_PULSE_CYCLES);

  logic [CNT_W-1:0]     cnt_r;
  logic [RST_WIDTH-1:0] rst_r;

  // Reset bits and shared hold counter. A new request reloads the counter so
  // every asserted bit is held a full pulse after the latest request; the
  // bits drop on the edge where the count runs out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_r <= '1;
      cnt_r <= CNT_LOAD;
    end else if (load) begin
      rst_r <= rst_r | set_bits;
      cnt_r <= CNT_LOAD;
    end else if (cnt_r <= CNT_W'(1)) begin
      rst_r <= '0;
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  assign rst_out = rst_r;

endmodule

// File: rtl/cntrl_spi_regs.sv
// ---------------------------------------------------------------------------
// cntrl_spi_regs
//   Control/status register bank behind the SPI slave. Decodes the 7-bit
//   address, holds the control registers driving reset, IRQ, LED, ADC DPRAM,
//   DDC and audio mux logic, and returns read data for MISO serialisation.
//   Ports:
//     clk, reset                 - system clock, asynchronous active-high reset
//     addr, wr_data, wr_en       - register write from spi_slave
//     rd_en, rd_data             - read-complete strobe / combinational read data
//     rst_out                    - sub-block resets (active-high)
//     irq_src, irq               - IRQ source levels / registered interrupt
//     led                        - LED control
//     dpram_addr, dpram_rdata    - ADC DPRAM read port (1-clk synchronous RAM)
//     ddc_en, ddc_lo_freq,
//     ddc_lo_freq_upd            - DDC enable, LO tuning word, update strobe
//     i2s_mux_sel                - audio I2S mux select
//   IRQ_WIDTH must not exceed 16.
// ---------------------------------------------------------------------------
module cntrl_spi_regs
  import cntrl_spi_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE         = 32'h1C3A0001,
  parameter int          DPRAM_AW         = 10,
  parameter int          RST_WIDTH        = 4,
  parameter int          RST_PULSE_CYCLES = 16,
  parameter int          IRQ_WIDTH        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           addr,
  input  logic [31:0]          wr_data,
  output logic [31:0]          rd_data,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [RST_WIDTH-1:0] rst_out,
  input  logic [IRQ_WIDTH-1:0] irq_src,
  output logic                 irq,
  output logic [1:0]           led,
  output logic [DPRAM_AW-1:0]  dpram_addr,
  input  logic [31:0]          dpram_rdata,
  output logic                 ddc_en,
  output logic [31:0]          ddc_lo_freq,
  output logic                 ddc_lo_freq_upd,
  output logic [1:0]           i2s_mux_sel
);

  // Per-register write strobes
  logic wr_rst_s;
  logic wr_irq_s;
  logic wr_led_s;
  logic wr_ainc_s;
  logic wr_dpaddr_s;
  logic wr_ddc_s;
  logic wr_lo_s;
  logic wr_i2s_s;

  logic                 rst_load_s;
  logic                 dpram_inc_s;
  logic [IRQ_WIDTH-1:0] irq_rise_s;
  logic [IRQ_WIDTH-1:0] irq_clr_s;
  logic [IRQ_WIDTH-1:0] irq_status_nxt_s;
  logic [31:0]          rd_data_s;

  logic [IRQ_WIDTH-1:0] irq_en_r;
  logic [IRQ_WIDTH-1:0] irq_status_r;
  logic [IRQ_WIDTH-1:0] irq_src_d_r;
  logic                 irq_r;
  logic [1:0]           led_r;
  logic                 ainc_r;
  logic [DPRAM_AW-1:0]  dpram_addr_r;
  logic                 ddc_en_r;
  logic [31:0]          ddc_lo_freq_r;
  logic                 ddc_lo_freq_upd_r;
  logic [1:0]           i2s_mux_sel_r;

  // Write address decode; unmapped and read-only addresses produce no strobe
  always_comb begin
    wr_rst_s    = 1'b0;
    wr_irq_s    = 1'b0;
    wr_led_s    = 1'b0;
    wr_ainc_s   = 1'b0;
    wr_dpaddr_s = 1'b0;
    wr_ddc_s    = 1'b0;
    wr_lo_s     = 1'b0;
    wr_i2s_s    = 1'b0;
    if (wr_en) begin
      case (addr)
        REG_RST_CNTRL:         wr_rst_s    = 1'b1;
        REG_IRQ_CNTRL_STATUS:  wr_irq_s    = 1'b1;
        REG_LED_CNTRL:         wr_led_s    = 1'b1;
        REG_ADC_DPRAM_CNTRL:   wr_ainc_s   = 1'b1;
        REG_ADC_DPRAM_ADDR:    wr_dpaddr_s = 1'b1;
        REG_DDC_CNTRL:         wr_ddc_s    = 1'b1;
        REG_DDC_LO_FREQ:       wr_lo_s     = 1'b1;
        REG_AUDIO_I2S_MUX_SEL: wr_i2s_s    = 1'b1;
        default:               wr_rst_s    = 1'b0;
      endcase
    end else begin
      wr_rst_s = 1'b0;
    end
  end

  // A zero write to RST_CNTRL must not restart the pulse
  assign rst_load_s = wr_rst_s && (wr_data[RST_WIDTH-1:0] != '0);

  cntrl_rst_pulse #(
    .RST_WIDTH        (RST_WIDTH),
    .RST_PULSE_CYCLES (RST_PULSE_CYCLES)
  ) u_rst_pulse (
    .clk      (clk),
    .reset    (reset),
    .load     (rst_load_s),
    .set_bits (wr_data[RST_WIDTH-1:0]),
    .rst_out  (rst_out)
  );

  // IRQ status next state: W1C clear first, then new rising edges so a set wins
  always_comb begin
    irq_rise_s = irq_src & ~irq_src_d_r;
    if (wr_irq_s) begin
      irq_clr_s = wr_data[IRQ_STATUS_LSB +: IRQ_WIDTH];
    end else begin
      irq_clr_s = '0;
    end
    irq_status_nxt_s = (irq_status_r & ~irq_clr_s) | irq_rise_s;
  end

  // IRQ enable/status registers, source edge history and registered irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_r     <= '0;
      irq_status_r <= '0;
      irq_src_d_r  <= '0;
      irq_r        <= 1'b0;
    end else begin
      if (wr_irq_s) begin
        irq_en_r <= wr_data[IRQ_WIDTH-1:0];
      end
      irq_status_r <= irq_status_nxt_s;
      irq_src_d_r  <= irq_src;
      irq_r        <= |(irq_status_r & irq_en_r);
    end
  end

  // Auto-increment only on a pure read of the DPRAM data register
  assign dpram_inc_s = rd_en && !wr_en && (addr == REG_ADC_DPRAM_DATA) && ainc_r;

  // DPRAM control and address; address wraps naturally at 2^DPRAM_AW
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ainc_r       <= 1'b0;
      dpram_addr_r <= '0;
    end else begin
      if (wr_ainc_s) begin
        ainc_r <= wr_data[DPRAM_AINC_BIT];
      end
      if (wr_dpaddr_s) begin
        dpram_addr_r <= wr_data[DPRAM_AW-1:0];
      end else if (dpram_inc_s) begin
        dpram_addr_r <= dpram_addr_r + DPRAM_AW'(1);
      end
    end
  end

  // LED, DDC and audio mux control registers; LO update strobe follows the write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r             <= 2'b00;
      ddc_en_r          <= 1'b0;
      ddc_lo_freq_r     <= 32'h0000_0000;
      ddc_lo_freq_upd_r <= 1'b0;
      i2s_mux_sel_r     <= 2'b00;
    end else begin
      if (wr_led_s) begin
        led_r <= wr_data[1:0];
      end
      if (wr_ddc_s) begin
        ddc_en_r <= wr_data[DDC_EN_BIT];
      end
      if (wr_lo_s) begin
        ddc_lo_freq_r <= wr_data;
      end
      ddc_lo_freq_upd_r <= wr_lo_s;
      if (wr_i2s_s) begin
        i2s_mux_sel_r <= wr_data[1:0];
      end
    end
  end

  // Read data mux; unmapped addresses and unused bits read 0
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (addr)
      REG_ID:                rd_data_s = ID_VALUE;
      REG_RST_CNTRL:         rd_data_s[RST_WIDTH-1:0] = rst_out;
      REG_IRQ_CNTRL_STATUS: begin
        rd_data_s[IRQ_WIDTH-1:0]                  = irq_en_r;
        rd_data_s[IRQ_STATUS_LSB +: IRQ_WIDTH]    = irq_status_r;
      end
      REG_LED_CNTRL:         rd_data_s[1:0] = led_r;
      REG_ADC_DPRAM_CNTRL:   rd_data_s[DPRAM_AINC_BIT] = ainc_r;
      REG_ADC_DPRAM_ADDR:    rd_data_s[DPRAM_AW-1:0] = dpram_addr_r;
      REG_ADC_DPRAM_DATA:    rd_data_s = dpram_rdata;
      REG_DDC_CNTRL:         rd_data_s[DDC_EN_BIT] = ddc_en_r;
      REG_DDC_LO_FREQ:       rd_data_s = ddc_lo_freq_r;
      REG_AUDIO_I2S_MUX_SEL: rd_data_s[1:0] = i2s_mux_sel_r;
      default:               rd_data_s = 32'h0000_0000;
    endcase
  end

  assign rd_data         = rd_data_s;
  assign irq             = irq_r;
  assign led             = led_r;
  assign dpram_addr      = dpram_addr_r;
  assign ddc_en          = ddc_en_r;
  assign ddc_lo_freq     = ddc_lo_freq_r;
  assign ddc_lo_freq_upd = ddc_lo_freq_upd_r;
  assign i2s_mux_sel     = i2s_mux_sel_r;

endmodule

// File: tb/tb_cntrl_spi_regs.sv
// ---------------------------------------------------------------------------
// tb_cntrl_spi_regs
//   Directed plus randomised stimulus for cntrl_spi_regs. Expected values
//   come from a behavioural model: the reset pulse is tracked as "bits held
//   until a release cycle", IRQ status as edge/clear set arithmetic, and the
//   DPRAM address as a modulo counter over a bench-owned memory.
// ---------------------------------------------------------------------------
module tb_cntrl_spi_regs;

  localparam int          AW    = 10;
  localparam int          RW    = 4;
  localparam int          PULSE = 16;
  localparam int          IW    = 8;
  localparam logic [31:0] ID    = 32'h1C3A0001;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          wr_en;
  logic          rd_en;
  logic [RW-1:0] rst_out;
  logic [IW-1:0] irq_src;
  logic          irq;
  logic [1:0]    led;
  logic [AW-1:0] dpram_addr;
  logic [31:0]   dpram_rdata;
  logic          ddc_en;
  logic [31:0]   ddc_lo_freq;
  logic          ddc_lo_freq_upd;
  logic [1:0]    i2s_mux_sel;

  always #5 clk = ~clk;

  cntrl_spi_regs #(
    .ID_VALUE(ID), .DPRAM_AW(AW), .RST_WIDTH(RW),
    .RST_PULSE_CYCLES(PULSE), .IRQ_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .wr_en(wr_en), .rd_en(rd_en), .rst_out(rst_out), .irq_src(irq_src), .irq(irq),
    .led(led), .dpram_addr(dpram_addr), .dpram_rdata(dpram_rdata), .ddc_en(ddc_en),
    .ddc_lo_freq(ddc_lo_freq), .ddc_lo_freq_upd(ddc_lo_freq_upd),
    .i2s_mux_sel(i2s_mux_sel)
  );

  // Synchronous 1-clk read RAM standing in for the ADC DPRAM
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) dpram_rdata <= mem[dpram_addr];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reset-pulse model: bits are held while cyc < rst_release
  int          rst_release = 0;
  logic [RW-1:0] rst_bits = '0;

  function automatic logic [RW-1:0] exp_rst();
    return (cyc < rst_release) ? rst_bits : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    if (a == 7'h01 && d[RW-1:0] != '0) begin
      if (cyc - 1 >= rst_release) rst_bits = '0;
      rst_bits = rst_bits | d[RW-1:0];
      rst_release = cyc + PULSE;
    end
  endtask

  task automatic rd(input logic [6:0] a);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [6:0] a, input logic [31:0] e);
    addr = a;
    #1;
    chk(tag, rd_data, e);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    rst_bits = '1;
    rst_release = cyc + PULSE;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0]  a_m;
    logic           ainc_m;
    logic [IW-1:0]  st_m, en_m, prev_m, src_n, clr_n, en_n, rise_m;
    logic           irq_e, do_clr;
    logic [31:0]    v, lo_m;
    int             op;

    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    reset = 1'b1; addr = 7'h00; wr_data = 32'h0; wr_en = 1'b0; rd_en = 1'b0;
    irq_src = '0;
    tick(); tick(); tick();

    // 1. reset state and power-on reset pulse
    chk("rst_out_in_reset", 32'(rst_out), 32'hF);
    chk("irq_in_reset", 32'(irq), 32'h0);
    chk("led_in_reset", 32'(led), 32'h0);
    chk("dpaddr_in_reset", 32'(dpram_addr), 32'h0);
    chk("lo_in_reset", ddc_lo_freq, 32'h0);
    chk("upd_in_reset", 32'(ddc_lo_freq_upd), 32'h0);
    release_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_pulse_por", 32'(rst_out), 32'(exp_rst()));
    end
    rdchk("id", 7'h00, ID);

    // 2. two overlapping reset requests
    wr(7'h01, 32'h2);
    chk("rst_req1", 32'(rst_out), 32'(exp_rst()));
    for (int i = 0; i < 8; i++) tick();
    wr(7'h01, 32'h4);
    chk("rst_or", 32'(rst_out), 32'h6);
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("rst_pulse_2", 32'(rst_out), 32'(exp_rst()));
    end
    rdchk("rst_read", 7'h01, 32'(rst_out));
    // random requests (including zero writes) with per-cycle checks
    for (int k = 0; k < 6; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 18)); g++) begin
        tick();
        chk("rst_rand_gap", 32'(rst_out), 32'(exp_rst()));
      end
      v = $urandom;
      if ($urandom_range(0, 2) == 0) v[RW-1:0] = '0;
      wr(7'h01, v);
      chk("rst_rand_wr", 32'(rst_out), 32'(exp_rst()));
      rdchk("rst_rand_rd", 7'h01, 32'(exp_rst()));
    end
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("rst_rand_tail", 32'(rst_out), 32'(exp_rst()));
    end

    // 3. IRQ directed
    wr(7'h02, 32'h0000_0005);
    rdchk("irq_en_rd", 7'h02, 32'h0000_0005);
    irq_src = 8'h01;
    tick();
    rdchk("irq_status_set", 7'h02, 32'h0001_0005);
    chk("irq_latency", 32'(irq), 32'h0);
    tick();
    chk("irq_assert", 32'(irq), 32'h1);
    irq_src = 8'h00;
    tick();
    irq_src = 8'h01;
    wr(7'h02, 32'h0001_0005);
    rdchk("irq_set_wins", 7'h02, 32'h0001_0005);
    tick();
    chk("irq_still", 32'(irq), 32'h1);
    wr(7'h02, 32'h0001_0005);
    rdchk("irq_w1c", 7'h02, 32'h0000_0005);
    tick();
    chk("irq_deassert", 32'(irq), 32'h0);
    irq_src = 8'h03;
    tick(); tick();
    rdchk("irq_masked_status", 7'h02, 32'h0002_0005);
    chk("irq_masked", 32'(irq), 32'h0);
    irq_src = 8'h00;
    tick();
    wr(7'h02, 32'h00FF_0000);
    rdchk("irq_cleared", 7'h02, 32'h0);
    // IRQ random: sources change every cycle, occasional W1C/enable writes
    st_m = '0; en_m = '0; prev_m = '0;
    tick();
    for (int i = 0; i < 40; i++) begin
      src_n = IW'($urandom);
      do_clr = ($urandom_range(0, 3) == 0);
      clr_n = IW'($urandom);
      en_n = IW'($urandom);
      irq_src = src_n;
      addr = 7'h02;
      wr_data = {8'h00, clr_n, 8'h00, en_n};
      wr_en = do_clr;
      irq_e = |(st_m & en_m);
      rise_m = src_n & ~prev_m;
      if (do_clr) begin
        st_m = st_m & ~clr_n;
        en_m = en_n;
      end
      st_m = st_m | rise_m;
      prev_m = src_n;
      tick();
      wr_en = 1'b0;
      chk("irq_rand_irq", 32'(irq), 32'(irq_e));
      rdchk("irq_rand_reg", 7'h02, {8'h00, st_m, 8'h00, en_m});
    end
    irq_src = '0;

    // 4. DPRAM address auto-increment with wrap
    wr(7'h10, 32'h1);
    wr(7'h11, 32'h3FF);
    a_m = 10'h3FF; ainc_m = 1'b1;
    tick();
    rdchk("dpram_data_3ff", 7'h12, mem[a_m]);
    rd(7'h12);
    a_m = a_m + 10'd1;
    chk("dpram_wrap", 32'(dpram_addr), 32'h0);
    tick();
    rdchk("dpram_data_0", 7'h12, mem[a_m]);
    rd(7'h12);
    chk("dpram_inc", 32'(dpram_addr), 32'h1);
    a_m = 10'h001;
    wr(7'h10, 32'h0);
    ainc_m = 1'b0;
    rd(7'h12);
    chk("dpram_noinc", 32'(dpram_addr), 32'h1);
    wr(7'h10, 32'h1);
    ainc_m = 1'b1;
    addr = 7'h12; wr_data = 32'hFFFF_FFFF; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("dpram_wr_rd_noinc", 32'(dpram_addr), 32'h1);
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin ainc_m = 1'($urandom); wr(7'h10, {31'h0, ainc_m}); end
        1: begin rd(7'h12); if (ainc_m) a_m = a_m + 10'd1; end
        2: begin v = $urandom; wr(7'h11, v); a_m = v[AW-1:0]; end
        default: begin
          addr = 7'h12; wr_en = 1'b1; rd_en = 1'b1;
          tick();
          wr_en = 1'b0; rd_en = 1'b0;
        end
      endcase
      chk("dpram_rand_addr", 32'(dpram_addr), 32'(a_m));
      tick();
      rdchk("dpram_rand_data", 7'h12, mem[a_m]);
      rdchk("dpram_rand_ainc", 7'h10, 32'(ainc_m));
    end

    // 5. DDC LO tuning word and update strobe
    wr(7'h20, 32'h1);
    chk("ddc_en", 32'(ddc_en), 32'h1);
    chk("upd_idle", 32'(ddc_lo_freq_upd), 32'h0);
    wr(7'h21, 32'h1234_5678);
    chk("lo_val", ddc_lo_freq, 32'h1234_5678);
    chk("lo_upd", 32'(ddc_lo_freq_upd), 32'h1);
    tick();
    chk("lo_upd_single", 32'(ddc_lo_freq_upd), 32'h0);
    rdchk("lo_read", 7'h21, 32'h1234_5678);
    lo_m = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      lo_m = $urandom;
      wr(7'h21, lo_m);
      chk("lo_rand_val", ddc_lo_freq, lo_m);
      chk("lo_rand_upd", 32'(ddc_lo_freq_upd), 32'h1);
      tick();
      chk("lo_rand_upd_off", 32'(ddc_lo_freq_upd), 32'h0);
    end

    // 6. unmapped address and unused bits
    wr(7'h03, 32'h1);
    wr(7'h30, 32'h2);
    wr(7'h7F, 32'hFFFF_FFFF);
    chk("unmap_led", 32'(led), 32'h1);
    chk("unmap_i2s", 32'(i2s_mux_sel), 32'h2);
    chk("unmap_ddc_en", 32'(ddc_en), 32'h1);
    chk("unmap_lo", ddc_lo_freq, lo_m);
    chk("unmap_upd", 32'(ddc_lo_freq_upd), 32'h0);
    chk("unmap_dpaddr", 32'(dpram_addr), 32'(a_m));
    chk("unmap_rst", 32'(rst_out), 32'(exp_rst()));
    rdchk("unmap_read", 7'h7F, 32'h0);
    wr(7'h03, 32'hFFFF_FFFF);
    rdchk("led_unused_bits", 7'h03, 32'h3);
    chk("led_out", 32'(led), 32'h3);
    wr(7'h30, 32'hFFFF_FFFF);
    rdchk("i2s_read", 7'h30, 32'h3);
    chk("i2s_out", 32'(i2s_mux_sel), 32'h3);

    // 7. asynchronous reset mid-operation restarts the pulse at full length
    wr(7'h01, 32'h8);
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out", 32'(rst_out), 32'hF);
    chk("async_led", 32'(led), 32'h0);
    chk("async_lo", ddc_lo_freq, 32'h0);
    chk("async_dpaddr", 32'(dpram_addr), 32'h0);
    chk("async_ddc_en", 32'(ddc_en), 32'h0);
    chk("async_i2s", 32'(i2s_mux_sel), 32'h0);
    tick(); tick();
    release_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_pulse_restart", 32'(rst_out), 32'(exp_rst()));
    end
    rdchk("irq_after_reset", 7'h02, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
